ripple_down_timer: RTL and testbench

- Loadable 8-bit down-counting timer; the counting-down counterpart to the existing free-running ripple up-counter.
- Shares the counter's `t` (toggle/count-enable) and `o` conventions.
- Counts a programmed value down to zero, pulses `done`, and optionally auto-reloads.
- Sits beside the up-counter in the lab timing block and drives interval and timeout events.

---
 rtl/ripple_down_timer_pkg.sv | 16 +
 rtl/ripple_down_timer_prescaler.sv | 50 +++++
 rtl/ripple_down_timer.sv | 126 ++++++++++++
 tb/tb_ripple_down_timer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ripple_down_timer_pkg.sv
// ---------------------------------------------------------------------------
// ripple_pkg
// Shared definitions for the ripple down-timer: controller state encoding
// and the default counter width.
// ---------------------------------------------------------------------------
package ripple_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_down_timer_prescaler.sv
// ---------------------------------------------------------------------------
// ripple_prescaler
// Divides enabled cycles by DIV: tick is asserted on every DIV-th cycle in
// which en is high. The phase holds while en is low, and clr returns it to 0.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   clr   - synchronous phase clear (has priority over en)
//   en    - advance enable
//   tick  - combinational, high when en=1 and the phase is DIV-1
// ---------------------------------------------------------------------------
module ripple_prescaler #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    // A one-bit counter that never leaves 0 is kept for DIV=1, so the
    // declaration stays legal.
    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ripple_down_timer.sv
// ---------------------------------------------------------------------------
// ripple_down_timer
// Loadable down-counting timer. It counts a programmed value down to zero,
// pulses done, and can auto-reload and continue. One decrement occurs per DIV
// enabled (t=1) cycles. Per-cycle priority is load > start > tick.
// Ports:
//   clock       - rising-edge clock
//   reset       - asynchronous active-low reset
//   t           - count enable (counting pauses while 0)
//   load        - strobe: capture load_val into reload register and count
//   load_val    - reload value
//   start       - strobe: begin / restart countdown
//   auto_reload - reload and keep running on expiry
//   o           - current count (registered)
//   zero        - o == 0 (combinational)
//   running     - controller is in RUN
//   done        - one-cycle registered expiry pulse
// ---------------------------------------------------------------------------
module ripple_down_timer
    import ripple_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DIV   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] o,
    output logic             zero,
    output logic             running,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             tick;
    logic             pre_en;
    logic             pre_clr;

    // The prescaler only advances while running and enabled. Any load or
    // start realigns its phase, so a restart always gets a full DIV period.
    assign pre_en  = (state_q == RUN) && t;
    assign pre_clr = load || start;

    ripple_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clr   (pre_clr),
        .en    (pre_en),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            reload_d = load_val;
            o_d      = load_val;
            state_d  = IDLE;
        end else if (start) begin
            // A tick on the same edge is discarded; start fully owns the edge.
            case (state_q)
                IDLE: begin
                    if (o_q != '0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    o_d = reload_q;
                end
                EXPIRED: begin
                    if (reload_q != '0) begin
                        o_d     = reload_q;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (tick) begin
            if (o_q > WIDTH'(1)) begin
                o_d = o_q - WIDTH'(1);
            end else if (o_q == WIDTH'(1)) begin
                done_d = 1'b1;
                if (auto_reload && (reload_q != '0)) begin
                    o_d = reload_q;
                end else begin
                    o_d     = '0;
                    state_d = EXPIRED;
                end
            end else begin
                // Never decrement through zero.
                state_d = EXPIRED;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            o_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign o       = o_q;
    assign zero    = (o_q == '0);
    assign running = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_ripple_down_timer.sv
module tb_ripple_down_timer;

    logic       clock;
    logic       reset;
    // DUT A: DIV=1
    logic       a_t, a_load, a_start, a_auto;
    logic [7:0] a_val;
    logic [7:0] a_o;
    logic       a_zero, a_running, a_done;
    // DUT B: DIV=4
    logic       b_t, b_load, b_start, b_auto;
    logic [7:0] b_val;
    logic [7:0] b_o;
    logic       b_zero, b_running, b_done;

    int chk_total = 0;
    int chk_pass  = 0;

    ripple_down_timer #(.WIDTH(8), .DIV(1)) dut_a (
        .clock(clock), .reset(reset), .t(a_t), .load(a_load), .load_val(a_val),
        .start(a_start), .auto_reload(a_auto), .o(a_o), .zero(a_zero),
        .running(a_running), .done(a_done)
    );

    ripple_down_timer #(.WIDTH(8), .DIV(4)) dut_b (
        .clock(clock), .reset(reset), .t(b_t), .load(b_load), .load_val(b_val),
        .start(b_start), .auto_reload(b_auto), .o(b_o), .zero(b_zero),
        .running(b_running), .done(b_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one active edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        chk_total++; if (a_o !== 8'd0) $display("FAIL rst_o: got %0d want 0", a_o); else chk_pass++;
        reset = 1'b1;
        step();
        chk_total++; if (a_o !== 8'd0) $display("FAIL idle_o: got %0d want 0", a_o); else chk_pass++;
        chk_total++; if (a_zero !== 1'b1) $display("FAIL idle_zero: got %b want 1", a_zero); else chk_pass++;
        chk_total++; if (a_running !== 1'b0) $display("FAIL idle_running: got %b want 0", a_running); else chk_pass++;
        chk_total++; if (a_done !== 1'b0) $display("FAIL idle_done: got %b want 0", a_done); else chk_pass++;
        chk_total++; if (b_o !== 8'd0 || b_running !== 1'b0) $display("FAIL idle_b: got o=%0d run=%b want 0/0", b_o, b_running); else chk_pass++;
    endtask

    task automatic test_countdown();
        a_t = 1'b1; a_auto = 1'b0;
        a_val = 8'd5; a_load = 1'b1;
        step();
        a_load = 1'b0;
        chk_total++; if (a_o !== 8'd5 || a_running !== 1'b0) $display("FAIL cd_load: got o=%0d run=%b want 5/0", a_o, a_running); else chk_pass++;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk_total++; if (a_o !== 8'd5 || a_running !== 1'b1) $display("FAIL cd_start: got o=%0d run=%b want 5/1", a_o, a_running); else chk_pass++;
        for (int i = 4; i >= 0; i--) begin
            step();
            chk_total++; if (a_o !== 8'(i)) $display("FAIL cd_o%0d: got %0d want %0d", i, a_o, i); else chk_pass++;
            chk_total++; if (a_done !== (i == 0)) $display("FAIL cd_done%0d: got %b want %b", i, a_done, (i == 0)); else chk_pass++;
        end
        chk_total++; if (a_running !== 1'b0 || a_zero !== 1'b1) $display("FAIL cd_expired: got run=%b zero=%b want 0/1", a_running, a_zero); else chk_pass++;
        step();
        chk_total++; if (a_done !== 1'b0 || a_o !== 8'd0) $display("FAIL cd_after: got done=%b o=%0d want 0/0", a_done, a_o); else chk_pass++;
        // Start from EXPIRED reloads the programmed value.
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk_total++; if (a_o !== 8'd5 || a_running !== 1'b1) $display("FAIL cd_rearm: got o=%0d run=%b want 5/1", a_o, a_running); else chk_pass++;
    endtask

    task automatic test_auto_reload();
        a_auto = 1'b1;
        a_val = 8'd3; a_load = 1'b1;
        step();
        a_load = 1'b0;
        chk_total++; if (a_running !== 1'b0) $display("FAIL ar_abort: got run=%b want 0", a_running); else chk_pass++;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk_total++; if (a_o !== ((k % 3 == 0) ? 8'd3 : 8'(3 - (k % 3)))) $display("FAIL ar_o%0d: got %0d", k, a_o); else chk_pass++;
            chk_total++; if (a_done !== (k % 3 == 0)) $display("FAIL ar_done%0d: got %b want %b", k, a_done, (k % 3 == 0)); else chk_pass++;
            chk_total++; if (a_running !== 1'b1) $display("FAIL ar_run%0d: got %b want 1", k, a_running); else chk_pass++;
        end
        a_auto = 1'b0;
        step(); step(); step();
        chk_total++; if (a_o !== 8'd0 || a_done !== 1'b1 || a_running !== 1'b0) $display("FAIL ar_stop: got o=%0d done=%b run=%b want 0/1/0", a_o, a_done, a_running); else chk_pass++;
    endtask

    task automatic test_pause();
        b_t = 1'b1; b_auto = 1'b0;
        b_val = 8'd2; b_load = 1'b1;
        step();
        b_load = 1'b0; b_start = 1'b1;
        step();
        b_start = 1'b0;
        step(); step();
        chk_total++; if (b_o !== 8'd2) $display("FAIL ps_pre: got %0d want 2", b_o); else chk_pass++;
        b_t = 1'b0;
        repeat (5) step();
        chk_total++; if (b_o !== 8'd2 || b_running !== 1'b1) $display("FAIL ps_frozen: got o=%0d run=%b want 2/1", b_o, b_running); else chk_pass++;
        b_t = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            chk_total++; if (b_o !== ((j < 2) ? 8'd2 : (j < 6) ? 8'd1 : 8'd0)) $display("FAIL ps_o%0d: got %0d", j, b_o); else chk_pass++;
            chk_total++; if (b_done !== (j == 6)) $display("FAIL ps_done%0d: got %b want %b", j, b_done, (j == 6)); else chk_pass++;
        end
        chk_total++; if (b_running !== 1'b0) $display("FAIL ps_end: got run=%b want 0", b_running); else chk_pass++;
    endtask

    task automatic test_edges();
        a_auto = 1'b0;
        a_val = 8'd7; a_load = 1'b1; a_start = 1'b1;
        step();
        a_load = 1'b0; a_start = 1'b0;
        chk_total++; if (a_o !== 8'd7 || a_running !== 1'b0) $display("FAIL ed_ldst: got o=%0d run=%b want 7/0", a_o, a_running); else chk_pass++;
        step();
        chk_total++; if (a_o !== 8'd7) $display("FAIL ed_idle_hold: got %0d want 7", a_o); else chk_pass++;
        a_val = 8'd0; a_load = 1'b1;
        step();
        a_load = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk_total++; if (a_running !== 1'b0 || a_o !== 8'd0) $display("FAIL ed_zero_start: got o=%0d run=%b want 0/0", a_o, a_running); else chk_pass++;
        a_auto = 1'b1; a_load = 1'b1;
        step();
        a_load = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        chk_total++; if (a_running !== 1'b0 || a_done !== 1'b0) $display("FAIL ed_zero_auto: got run=%b done=%b want 0/0", a_running, a_done); else chk_pass++;
        // Restart in RUN: the coincident tick is dropped.
        a_auto = 1'b0; a_val = 8'd4; a_load = 1'b1;
        step();
        a_load = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        chk_total++; if (a_o !== 8'd3) $display("FAIL ed_run: got %0d want 3", a_o); else chk_pass++;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk_total++; if (a_o !== 8'd4 || a_running !== 1'b1) $display("FAIL ed_restart: got o=%0d run=%b want 4/1", a_o, a_running); else chk_pass++;
        step();
        chk_total++; if (a_o !== 8'd3) $display("FAIL ed_restart_next: got %0d want 3", a_o); else chk_pass++;
    endtask

    task automatic test_reset_mid_run();
        a_auto = 1'b0; a_val = 8'd200; a_load = 1'b1;
        step();
        a_load = 1'b0; a_start = 1'b1;
        step();
        a_start = 1'b0;
        repeat (50) step();
        chk_total++; if (a_o !== 8'd150) $display("FAIL mr_count: got %0d want 150", a_o); else chk_pass++;
        reset = 1'b0;
        #1;
        chk_total++; if (a_o !== 8'd0 || a_zero !== 1'b1) $display("FAIL mr_async: got o=%0d zero=%b want 0/1", a_o, a_zero); else chk_pass++;
        chk_total++; if (a_running !== 1'b0 || a_done !== 1'b0) $display("FAIL mr_ctrl: got run=%b done=%b want 0/0", a_running, a_done); else chk_pass++;
        step();
        reset = 1'b1;
        step();
        chk_total++; if (a_done !== 1'b0 || a_o !== 8'd0) $display("FAIL mr_after: got done=%b o=%0d want 0/0", a_done, a_o); else chk_pass++;
    endtask

    initial begin
        reset = 1'b1;
        a_t = 1'b0; a_load = 1'b0; a_start = 1'b0; a_auto = 1'b0; a_val = 8'd0;
        b_t = 1'b0; b_load = 1'b0; b_start = 1'b0; b_auto = 1'b0; b_val = 8'd0;
        #2;
        test_reset();
        test_countdown();
        test_auto_reload();
        test_pause();
        test_edges();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
